dbus_arbiter: RTL and testbench

//   Two-master round-robin arbiter for the shared 32-bit DBus that feeds the data RAM and other DBus slaves.

---
 rtl/dbus_arbiter.sv | 131 +++++++++++++
 tb/tb_dbus_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter for the shared 32-bit DBus.
// Grant is combinational from requests and arbitration state. The winning master's
// transfer is muxed onto the slave side. 1-cycle-latency read data is steered back
// to the master that issued the read. A master may take at most MAX_BURST
// consecutive grants while the other master is waiting.
module dbus_arbiter #(
  parameter int ADDR_WIDTH = 30,
  parameter int MAX_BURST  = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rstn,
  input  logic [ADDR_WIDTH-1:0] i_M0Addr,
  input  logic                  i_M0Re,
  input  logic                  i_M0We,
  input  logic [3:0]            i_M0ByteEn,
  input  logic [31:0]           i_M0Wd,
  output logic                  o_M0Gnt,
  output logic [31:0]           o_M0Rd,
  output logic                  o_M0RdValid,
  input  logic [ADDR_WIDTH-1:0] i_M1Addr,
  input  logic                  i_M1Re,
  input  logic                  i_M1We,
  input  logic [3:0]            i_M1ByteEn,
  input  logic [31:0]           i_M1Wd,
  output logic                  o_M1Gnt,
  output logic [31:0]           o_M1Rd,
  output logic                  o_M1RdValid,
  output logic [ADDR_WIDTH-1:0] o_DBusAddr,
  output logic                  o_DBusRe,
  output logic                  o_DBusWe,
  output logic [3:0]            o_DBusByteEn,
  output logic [31:0]           o_DBusWd,
  input  logic [31:0]           i_DBusRd
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  // last_q: 0 = M0, 1 = M1
  logic       last_q, last_d;
  logic [3:0] burst_q, burst_d;
  logic       rd_owner_v_q, rd_owner_v_d;
  logic       rd_owner_q, rd_owner_d;

  logic req0, req1;
  logic sel;

  assign req0 = i_M0Re | i_M0We;
  assign req1 = i_M1Re | i_M1We;

  // Grant selection. With no burst in progress (count 0) or an exhausted burst,
  // contention goes to the master that was not granted last. Otherwise the
  // current burst continues. Grants are held off while reset is asserted.
  always_comb begin
    o_M0Gnt = 1'b0;
    o_M1Gnt = 1'b0;
    sel     = 1'b0;
    if (i_Rstn) begin
      if (req0 && !req1) begin
        o_M0Gnt = 1'b1;
      end else if (req1 && !req0) begin
        o_M1Gnt = 1'b1;
      end else if (req0 && req1) begin
        if (burst_q == 4'd0 || burst_q == MAX_CNT) sel = ~last_q;
        else                                        sel = last_q;
        o_M0Gnt = ~sel;
        o_M1Gnt = sel;
      end
    end
  end

  // Slave-side mux. The bus is driven to all zeros when nothing is granted.
  always_comb begin
    o_DBusAddr   = '0;
    o_DBusRe     = 1'b0;
    o_DBusWe     = 1'b0;
    o_DBusByteEn = 4'b0;
    o_DBusWd     = 32'b0;
    if (o_M0Gnt) begin
      o_DBusAddr   = i_M0Addr;
      o_DBusRe     = i_M0Re;
      o_DBusWe     = i_M0We;
      o_DBusByteEn = i_M0ByteEn;
      o_DBusWd     = i_M0Wd;
    end else if (o_M1Gnt) begin
      o_DBusAddr   = i_M1Addr;
      o_DBusRe     = i_M1Re;
      o_DBusWe     = i_M1We;
      o_DBusByteEn = i_M1ByteEn;
      o_DBusWd     = i_M1Wd;
    end
  end

  // Next-state logic: burst tracking and read-ownership capture.
  always_comb begin
    last_d       = last_q;
    burst_d      = 4'd0;
    rd_owner_v_d = (o_M0Gnt & i_M0Re) | (o_M1Gnt & i_M1Re);
    rd_owner_d   = rd_owner_q;
    if (o_M0Gnt || o_M1Gnt) begin
      if (o_M1Gnt == last_q) begin
        burst_d = (burst_q == MAX_CNT) ? MAX_CNT : burst_q + 4'd1;
      end else begin
        burst_d = 4'd1;
        last_d  = o_M1Gnt;
      end
    end
    if (rd_owner_v_d) rd_owner_d = o_M1Gnt;
  end

  // State registers. Reset leaves M1 as last granted so M0 wins first contention.
  // Clearing the owner-valid bit drops any read still in flight.
  always_ff @(posedge i_Clk or negedge i_Rstn) begin
    if (!i_Rstn) begin
      last_q       <= 1'b1;
      burst_q      <= 4'd0;
      rd_owner_v_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      last_q       <= last_d;
      burst_q      <= burst_d;
      rd_owner_v_q <= rd_owner_v_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign o_M0RdValid = rd_owner_v_q & ~rd_owner_q;
  assign o_M1RdValid = rd_owner_v_q &  rd_owner_q;
  assign o_M0Rd      = o_M0RdValid ? i_DBusRd : 32'b0;
  assign o_M1Rd      = o_M1RdValid ? i_DBusRd : 32'b0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter. Inputs change 1 ns after a rising edge.
// Outputs are sampled 4 ns after the edge, well before the next one.
module tb_dbus_arbiter;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_re, m0_we, m1_re, m1_we;
  logic [3:0]    m0_be, m1_be;
  logic [31:0]   m0_wd, m1_wd;
  logic          m0_gnt, m1_gnt, m0_rdv, m1_rdv;
  logic [31:0]   m0_rd, m1_rd;
  logic [AW-1:0] bus_addr;
  logic          bus_re, bus_we;
  logic [3:0]    bus_be;
  logic [31:0]   bus_wd, bus_rd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dbus_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(4)) dut (
    .i_Clk(clk), .i_Rstn(rstn),
    .i_M0Addr(m0_addr), .i_M0Re(m0_re), .i_M0We(m0_we), .i_M0ByteEn(m0_be), .i_M0Wd(m0_wd),
    .o_M0Gnt(m0_gnt), .o_M0Rd(m0_rd), .o_M0RdValid(m0_rdv),
    .i_M1Addr(m1_addr), .i_M1Re(m1_re), .i_M1We(m1_we), .i_M1ByteEn(m1_be), .i_M1Wd(m1_wd),
    .o_M1Gnt(m1_gnt), .o_M1Rd(m1_rd), .o_M1RdValid(m1_rdv),
    .o_DBusAddr(bus_addr), .o_DBusRe(bus_re), .o_DBusWe(bus_we),
    .o_DBusByteEn(bus_be), .o_DBusWd(bus_wd), .i_DBusRd(bus_rd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    m0_addr = '0; m0_re = 0; m0_we = 0; m0_be = 0; m0_wd = 0;
    m1_addr = '0; m1_re = 0; m1_we = 0; m1_be = 0; m1_wd = 0;
    bus_rd  = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_all();
    rstn = 1'b0;
    step(); step();
    rstn = 1'b1;
  endtask

  bit exp_m0 [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
  int run;
  logic run_m;

  initial begin
    idle_all();
    rstn = 1'b0;
    #2;
    // Requests present during reset must not produce grants or bus enables
    m0_re = 1; m0_addr = 30'h1; m1_we = 1;
    #3;
    check("rst_m0gnt", 32'(m0_gnt), 0);
    check("rst_m1gnt", 32'(m1_gnt), 0);
    check("rst_busre", 32'(bus_re), 0);
    check("rst_buswe", 32'(bus_we), 0);
    check("rst_rdv",   32'({m0_rdv, m1_rdv}), 0);

    // Single M0 read after reset release
    do_reset();
    m0_re = 1; m0_addr = 30'h1;
    #3;
    check("rd1_m0gnt", 32'(m0_gnt), 1);
    check("rd1_m1gnt", 32'(m1_gnt), 0);
    check("rd1_busre", 32'(bus_re), 1);
    check("rd1_addr",  32'(bus_addr), 32'h1);
    step();
    idle_all(); bus_rd = 32'h1234_5678;
    #3;
    check("rd1_m0rdv", 32'(m0_rdv), 1);
    check("rd1_m0rd",  m0_rd, 32'h1234_5678);
    check("rd1_m1rdv", 32'(m1_rdv), 0);
    check("rd1_m1rd",  m1_rd, 0);

    // First contention after reset goes to M0; then continuous contention
    do_reset();
    m0_re = 1; m0_addr = 30'h10; m0_be = 4'hF;
    m1_we = 1; m1_addr = 30'h20; m1_be = 4'h5; m1_wd = 32'hCAFE_F00D;
    #3;
    check("cont_busre", 32'(bus_re), 1);
    check("cont_buswe", 32'(bus_we), 0);
    check("cont_buswd", bus_wd, 0);
    check("cont_busbe", 32'(bus_be), 32'hF);
    run = 0; run_m = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) #3;
      check($sformatf("pat%0d_m0gnt", i), 32'(m0_gnt), 32'(exp_m0[i]));
      check($sformatf("pat%0d_m1gnt", i), 32'(m1_gnt), 32'(!exp_m0[i]));
      check($sformatf("pat%0d_addr", i), 32'(bus_addr), exp_m0[i] ? 32'h10 : 32'h20);
      if (i != 0 && m1_gnt == run_m) run++;
      else begin run = 1; run_m = m1_gnt; end
      check($sformatf("pat%0d_run_gt4", i), 32'(run > 4), 0);
      step();
    end

    // Alternating reads M0 then M1, data routed to the issuing master
    do_reset();
    m0_re = 1; m0_addr = 30'h2;
    #3;
    check("alt_m0gnt", 32'(m0_gnt), 1);
    check("alt_addr0", 32'(bus_addr), 32'h2);
    step();
    idle_all(); m1_re = 1; m1_addr = 30'h3; bus_rd = 32'h6C6C_6548;
    #3;
    check("alt_m1gnt", 32'(m1_gnt), 1);
    check("alt_addr1", 32'(bus_addr), 32'h3);
    check("alt_m0rdv", 32'(m0_rdv), 1);
    check("alt_m0rd",  m0_rd, 32'h6C6C_6548);
    check("alt_m1rdv_a", 32'(m1_rdv), 0);
    step();
    idle_all(); bus_rd = 32'h6F57_206F;
    #3;
    check("alt_m1rdv", 32'(m1_rdv), 1);
    check("alt_m1rd",  m1_rd, 32'h6F57_206F);
    check("alt_m0rdv_b", 32'(m0_rdv), 0);
    check("alt_m0rd_b",  m0_rd, 0);

    // M1 write while M0 idle
    step();
    m1_we = 1; m1_addr = 30'h4; m1_be = 4'b0011; m1_wd = 32'hDEAD_BEEF;
    #3;
    check("wr_m1gnt", 32'(m1_gnt), 1);
    check("wr_buswe", 32'(bus_we), 1);
    check("wr_busre", 32'(bus_re), 0);
    check("wr_addr",  32'(bus_addr), 32'h4);
    check("wr_be",    32'(bus_be), 32'h3);
    check("wr_wd",    bus_wd, 32'hDEAD_BEEF);
    step();
    idle_all(); bus_rd = 32'hAAAA_5555;
    #3;
    check("wr_nordv", 32'({m0_rdv, m1_rdv}), 0);
    check("idle_busbe", 32'(bus_be), 0);

    // Read in flight dropped by a reset pulse; M0 wins contention afterwards
    step();
    idle_all(); m1_re = 1; m1_addr = 30'h7;
    #3;
    check("pre_m1gnt", 32'(m1_gnt), 1);
    step();
    idle_all(); m0_re = 1; m0_addr = 30'h9;
    #3;
    check("rrst_m0gnt", 32'(m0_gnt), 1);
    rstn = 1'b0;
    #1;
    check("rrst_gnt_low", 32'(m0_gnt), 0);
    check("rrst_m0rdv",   32'(m0_rdv), 0);
    check("rrst_m1rdv",   32'(m1_rdv), 0);
    #1;
    rstn = 1'b1;
    idle_all(); bus_rd = 32'h5A5A_5A5A;
    step();
    #3;
    check("rrst_late_rdv", 32'({m0_rdv, m1_rdv}), 0);
    step();
    m0_we = 1; m0_addr = 30'hA; m1_re = 1; m1_addr = 30'hB;
    #3;
    check("rrst_cont_m0", 32'(m0_gnt), 1);
    check("rrst_cont_m1", 32'(m1_gnt), 0);
    check("rrst_cont_addr", 32'(bus_addr), 32'hA);
    step();
    idle_all();
    #3;
    check("rrst_wr_nordv", 32'({m0_rdv, m1_rdv}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
